keypad_key_buffer: RTL and testbench
====================================

// Module: keypad_key_buffer
// PURPOSE
//  MCU-side reader for the keypad scanner. Captures each 4-bit key code
//  announced by the scanner's interrupt strobe into a small FIFO.
//  Raises an interrupt request toward the MCU and presents the oldest code
//  on an 8-bit IN-port data word. The MCU pops codes one at a time with a
//  read strobe, so bursts of key presses are not lost between ISR calls.
// PARAMETERS
//  DEPTH  4  FIFO entries; power of two, >= 2
//  AW     2  pointer width, = $clog2(DEPTH)
// PORTS
//  CLK       in   1  system clock; the same clock that drives the scanner's interrupt FSM
//  RST_N     in   1  asynchronous, active-low reset
//  KEY_CODE  in   4  key code from the scanner output register
//  KEY_STROBE in  1  scanner interrupt line; a rising edge means a new key
//  RD_EN     in   1  MCU IN-port read strobe for this port; pops one entry
//  CLR       in   1  synchronous flush; clears the FIFO and the overflow flag
//  DATA_OUT  out  8  {VALID, OVERFLOW, 2'b00, CODE[3:0]}
//  INTR      out  1  interrupt request to the MCU
//  EMPTY     out  1  FIFO holds 0 entries
//  FULL      out  1  FIFO holds DEPTH entries
//  OVERFLOW  out  1  sticky: a key was dropped because the FIFO was full
// BEHAVIOUR
//  - Reset (RST_N=0, asynchronous): pointers=0, count=0, strobe_q=0,
//    OVERFLOW=0. Outputs: EMPTY=1, FULL=0, INTR=0, DATA_OUT=8'h00.
//  - Edge detect: strobe_q <= KEY_STROBE each cycle; push_req = KEY_STROBE & ~strobe_q.
//    Exactly one push per rising edge; a held-high strobe gives no repeat push.
//  - KEY_CODE is sampled in the same cycle as push_req. The scanner holds
//    it stable while the strobe is high.
//  - Push accepted if (~FULL | pop_ok). Write code at wr_ptr; wr_ptr+1,
//    wrapping mod DEPTH.
//  - pop_ok = RD_EN & ~EMPTY. rd_ptr+1, wrapping mod DEPTH. RD_EN while
//    EMPTY is ignored: no pointer change, no error.
//  - count is AW+1 bits. +1 on push only, -1 on pop only, unchanged on push+pop.
//    EMPTY = (count==0), FULL = (count==DEPTH).
//  - Push when FULL with no pop in the same cycle: code dropped, FIFO
//    unchanged, OVERFLOW <= 1. OVERFLOW stays set until CLR or reset.
//  - Push while EMPTY combined with RD_EN: pop ignored, push accepted, count=1.
//  - CLR has priority over push and pop in the same cycle. Result: count=0,
//    pointers=0, OVERFLOW=0, and any coincident push is discarded.
//  - DATA_OUT is combinational from registers, so the MCU sees the head in
//    the IN cycle (zero latency). VALID = ~EMPTY. CODE = head entry, or 4'h0
//    when EMPTY. The pop takes effect at the clock edge ending the RD_EN cycle.
//  - Push-to-visible latency: 1 CLK. The code appears on DATA_OUT the cycle
//    after the strobe edge.
//  - Reset asserted mid-operation clears everything immediately. Stored keys are lost.
// CONFIGURATION
//  KEYBUF_INT_PULSE_EN undefined (default): INTR = ~EMPTY, a level request
//    that stays high until the ISR drains the FIFO.
//  KEYBUF_INT_PULSE_EN defined: INTR is a registered 1-CLK pulse the cycle
//    after each accepted push. No pulse for a dropped push, a pop, or CLR.
//    INTR=0 at reset.
// TESTING
//  1. Reset, then strobe edge with KEY_CODE=4'h5 -> next cycle DATA_OUT=8'h85,
//     EMPTY=0, INTR=1; RD_EN 1 cycle -> DATA_OUT=8'h00, EMPTY=1, INTR=0.
//  2. KEY_STROBE held high 10 cycles with code 4'h3 -> exactly one entry
//     (count=1); a second edge with 4'h7 -> pops return 3 then 7, in order.
//  3. Push codes 1,2,3,4 (FULL=1), then push 9 -> OVERFLOW=1, DATA_OUT=8'hC1;
//     four pops -> 1,2,3,4, with bit6 still 1; CLR -> DATA_OUT=8'h00, OVERFLOW=0.
//  4. FULL with entries 1,2,3,4; push 4'hA in the same cycle as RD_EN ->
//     count stays 4, OVERFLOW=0; drain order is 2,3,4,A.
//  5. RD_EN while EMPTY -> no change. Push 4'hE and RD_EN in the same cycle
//     while EMPTY -> count=1, DATA_OUT=8'h8E.
//  6. Two entries held, RST_N low mid-cycle -> EMPTY=1, DATA_OUT=8'h00
//     without waiting for a clock edge. With KEYBUF_INT_PULSE_EN, three pushes
//     -> exactly three 1-cycle INTR pulses.

Source files
------------

// File: rtl/keypad_key_buffer.sv
// Key-code FIFO between the keypad scanner interrupt and the MCU IN port.
// Define KEYBUF_INT_PULSE_EN for a one-cycle INTR pulse per accepted key; otherwise INTR is a level (~EMPTY).
module keypad_key_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [3:0] KEY_CODE,
    input  logic       KEY_STROBE,
    input  logic       RD_EN,
    input  logic       CLR,
    output logic [7:0] DATA_OUT,
    output logic       INTR,
    output logic       EMPTY,
    output logic       FULL,
    output logic       OVERFLOW
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [3:0]    mem_q [DEPTH];
    logic [3:0]    mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          strobe_q;
    logic          overflow_q, overflow_d;
    logic          push_req, push_ok, pop_ok;

    assign EMPTY    = (count_q == '0);
    assign FULL     = (count_q == FULL_CNT);
    assign OVERFLOW = overflow_q;
    assign DATA_OUT = {~EMPTY, overflow_q, 2'b00, EMPTY ? 4'h0 : mem_q[rd_ptr_q]};

    assign push_req = KEY_STROBE & ~strobe_q;
    assign pop_ok   = RD_EN & ~EMPTY;
    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign push_ok  = push_req & (~FULL | pop_ok);

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (CLR) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = KEY_CODE;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push_ok && !pop_ok) begin
                count_d = count_q + (AW+1)'(1);
            end else if (pop_ok && !push_ok) begin
                count_d = count_q - (AW+1)'(1);
            end
            if (push_req && !push_ok) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 4'h0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            strobe_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            strobe_q   <= KEY_STROBE;
            overflow_q <= overflow_d;
        end
    end

`ifdef KEYBUF_INT_PULSE_EN
    logic intr_q, intr_d;

    assign intr_d = push_ok & ~CLR;
    assign INTR   = intr_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            intr_q <= 1'b0;
        end else begin
            intr_q <= intr_d;
        end
    end
`else
    assign INTR = ~EMPTY;
`endif

endmodule

// File: tb/tb_keypad_key_buffer.sv
// Scoreboard bench for keypad_key_buffer: queue-based reference model, directed cases then random traffic.
module tb_keypad_key_buffer;

    localparam int DEPTH = 4;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [3:0] KEY_CODE = 4'h0;
    logic       KEY_STROBE = 1'b0;
    logic       RD_EN = 1'b0;
    logic       CLR = 1'b0;
    logic [7:0] DATA_OUT;
    logic       INTR, EMPTY, FULL, OVERFLOW;

    keypad_key_buffer #(.DEPTH(DEPTH), .AW(2)) dut (
        .CLK(CLK), .RST_N(RST_N), .KEY_CODE(KEY_CODE), .KEY_STROBE(KEY_STROBE),
        .RD_EN(RD_EN), .CLR(CLR), .DATA_OUT(DATA_OUT), .INTR(INTR),
        .EMPTY(EMPTY), .FULL(FULL), .OVERFLOW(OVERFLOW)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    logic [3:0] mq[$];   // model FIFO contents, oldest first
    logic [3:0] sbq[$];  // codes the MCU is expected to read, in order
    bit movf = 0;
    bit mprev = 0;
    bit mpulse = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_state(input string tag);
        logic [7:0] exp_d;
        logic       exp_intr;
        exp_d = {mq.size() != 0, movf, 2'b00, (mq.size() != 0) ? mq[0] : 4'h0};
`ifdef KEYBUF_INT_PULSE_EN
        exp_intr = mpulse;
`else
        exp_intr = (mq.size() != 0);
`endif
        chk({tag, "_data"}, DATA_OUT, exp_d);
        chk({tag, "_empty"}, {7'd0, EMPTY}, {7'd0, mq.size() == 0});
        chk({tag, "_full"}, {7'd0, FULL}, {7'd0, mq.size() == DEPTH});
        chk({tag, "_ovf"}, {7'd0, OVERFLOW}, {7'd0, movf});
        chk({tag, "_intr"}, {7'd0, INTR}, {7'd0, exp_intr});
    endtask

    // Apply one cycle of inputs, advance the model by the rules, check after the edge.
    task automatic cycle(input bit s, input logic [3:0] c, input bit rd, input bit clr);
        bit push;
        KEY_STROBE = s;
        KEY_CODE   = c;
        RD_EN      = rd;
        CLR        = clr;
        push   = s && !mprev;
        mprev  = s;
        mpulse = 0;
        if (clr) begin
            mq.delete();
            movf = 0;
        end else begin
            if (rd && mq.size() > 0) sbq.push_back(mq.pop_front());
            if (push) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back(c);
                    mpulse = 1;
                end else begin
                    movf = 1;
                end
            end
        end
        @(posedge CLK);
        #1;
        check_state("cyc");
    endtask

    task automatic push_key(input logic [3:0] c);
        cycle(1, c, 0, 0);
        cycle(0, c, 0, 0);
    endtask

    // Monitor: every real pop is compared against the scoreboard head.
    always @(negedge CLK) begin
        logic [3:0] exp;
        if (RST_N && RD_EN && !CLR && DATA_OUT[7]) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL pop_unexpected actual=%h required=none t=%0t", DATA_OUT, $time);
            end else begin
                exp = sbq.pop_front();
                chk("pop_code", {4'h0, DATA_OUT[3:0]}, {4'h0, exp});
            end
        end
    end

    initial begin
        int np;
        RST_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_data", DATA_OUT, 8'h00);
        chk("rst_empty", {7'd0, EMPTY}, 8'd1);
        chk("rst_intr", {7'd0, INTR}, 8'd0);
        RST_N = 1'b1;

        // Single key then read
        cycle(1, 4'h5, 0, 0);
        chk("t1_data", DATA_OUT, 8'h85);
        cycle(0, 4'h5, 1, 0);
        chk("t1_drain", DATA_OUT, 8'h00);

        // Held strobe gives one entry
        for (int i = 0; i < 10; i++) cycle(1, 4'h3, 0, 0);
        cycle(0, 4'h3, 0, 0);
        push_key(4'h7);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 1, 0);
        chk("t2_empty", {7'd0, EMPTY}, 8'd1);

        // Overflow, drain, clear
        push_key(4'h1); push_key(4'h2); push_key(4'h3); push_key(4'h4);
        chk("t3_full", {7'd0, FULL}, 8'd1);
        push_key(4'h9);
        chk("t3_ovf", DATA_OUT, 8'hC1);
        repeat (4) cycle(0, 0, 1, 0);
        chk("t3_sticky", DATA_OUT, 8'h40);
        cycle(0, 0, 0, 1);
        chk("t3_clr", DATA_OUT, 8'h00);

        // Push and pop together while full
        push_key(4'h1); push_key(4'h2); push_key(4'h3); push_key(4'h4);
        cycle(1, 4'hA, 1, 0);
        chk("t4_full", {6'd0, FULL, OVERFLOW}, 8'h02);
        cycle(0, 4'hA, 0, 0);
        repeat (4) cycle(0, 0, 1, 0);

        // Read while empty, then push with read while empty
        cycle(0, 0, 1, 0);
        cycle(1, 4'hE, 1, 0);
        chk("t5_data", DATA_OUT, 8'h8E);
        cycle(0, 0, 1, 0);

        // Asynchronous reset mid-cycle
        push_key(4'h6); push_key(4'h8);
        #2;
        RST_N = 1'b0;
        #1;
        chk("t6_rst_empty", {7'd0, EMPTY}, 8'd1);
        chk("t6_rst_data", DATA_OUT, 8'h00);
        mq.delete(); movf = 0; mprev = 0; mpulse = 0;
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        check_state("t6_post");

`ifdef KEYBUF_INT_PULSE_EN
        np = 0;
        for (int i = 0; i < 3; i++) begin
            cycle(1, 4'(i + 2), 0, 0);
            np += int'(INTR);
            cycle(0, 0, 0, 0);
            np += int'(INTR);
        end
        chk("t6_pulses", 8'(np), 8'd3);
        cycle(0, 0, 0, 1);
`endif

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  $urandom_range(0, 9) < 3, $urandom_range(0, 99) < 3);
        end
        repeat (DEPTH) cycle(0, 0, 1, 0);

        chk("sb_leftover", 8'(sbq.size()), 8'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
